// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and bit-period arithmetic.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial input front end: 2-FF synchroniser, falling-edge detect and
// 3-sample majority voter around mid-bit.
module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1,
   parameter int   CNT_W   = 4,
   parameter int   HALF    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx,
   input  logic [CNT_W-1:0] clk_cnt,
   output logic             rx_s,
   output logic             fall,
   output logic             vote
);

   localparam logic [CNT_W-1:0] CNT_SMP_A = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_SMP_B = CNT_W'(HALF);

   logic rx_m;
   logic rx_d;
   logic smp_a;
   logic smp_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m  <= RST_VAL;
         rx_s  <= RST_VAL;
         rx_d  <= RST_VAL;
         smp_a <= RST_VAL;
         smp_b <= RST_VAL;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
         if (clk_cnt == CNT_SMP_A) smp_a <= rx_s;
         if (clk_cnt == CNT_SMP_B) smp_b <= rx_s;
      end
   end

   assign fall = rx_d & ~rx_s;

   // Third sample is the live rx_s, so the vote is valid while clk_cnt == HALF+1.
   assign vote = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start-bit validation, mid-bit majority sampling, LSB-first
// deserialisation, framing-error detection and break recovery.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int BAUD_RATE = 4800,
   parameter int DATA_BITS = 8,
   parameter int CLK_FREQ  = 27_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 received_signal,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_ready,
   output logic                 frame_error,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int BIT_W        = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   uart_state_t          state;
   uart_state_t          state_n;
   logic [CNT_W-1:0]     clk_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_s;
   logic                 fall;
   logic                 vote;
   logic                 mid;
   logic                 wrap;
   logic                 load;
   logic                 ferr;

   uart_rx_sync #(
      .RST_VAL (1'b1),
      .CNT_W   (CNT_W),
      .HALF    (HALF)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx      (received_signal),
      .clk_cnt (clk_cnt),
      .rx_s    (rx_s),
      .fall    (fall),
      .vote    (vote)
   );

   assign mid  = (clk_cnt == CNT_MID);
   assign wrap = (clk_cnt == CNT_LAST);
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      ferr    = 1'b0;
      case (state)
         IDLE:  if (fall) state_n = START;
         START: begin
            if (mid && vote) state_n = IDLE;
            else if (wrap)   state_n = DATA;
         end
         DATA:  if (wrap && (bit_cnt == BIT_LAST)) state_n = STOP;
         STOP: begin
            if (mid) begin
               if (vote) begin
                  load    = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_n = BREAK;
               end
            end
         end
         BREAK: if (rx_s) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // The edge-detect cycle in IDLE counts as tick 0 of the start bit, so START begins at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt     <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         data        <= '0;
         data_ready  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         data_ready  <= load;
         frame_error <= ferr;
         if (load) data <= shreg;

         if ((state_n == IDLE) || (state_n == BREAK)) clk_cnt <= '0;
         else if (wrap)                               clk_cnt <= '0;
         else                                         clk_cnt <= clk_cnt + CNT_W'(1);

         if (state == IDLE)               bit_cnt <= '0;
         else if ((state == DATA) && wrap) bit_cnt <= bit_cnt + BIT_W'(1);

         if ((state == DATA) && mid) shreg <= {vote, shreg[DATA_BITS-1:1]};
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames against a frame-level model of the UART receiver.
module tb_uart_receiver;

   localparam int CF   = 160;
   localparam int BR   = 10;
   localparam int DB   = 8;
   localparam int CPB  = CF / BR;
   localparam int HALF = CPB / 2;
   // Pin-low to data_ready: (DB+1) bit periods + HALF+2 clks + 2 clks synchroniser.
   localparam int LAT  = (DB + 1) * CPB + HALF + 2 + 2;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          line  = 1'b1;
   logic [DB-1:0] data;
   logic          data_ready;
   logic          frame_error;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rdy_cnt = 0;
   int ferr_cnt = 0;
   int last_rdy_cyc = 0;
   int both_seen = 0;
   int start_cyc = 0;

   logic [DB-1:0] exp_data = '0;
   int exp_rdy = 0;
   int exp_ferr = 0;

   uart_receiver #(
      .BAUD_RATE (BR),
      .DATA_BITS (DB),
      .CLK_FREQ  (CF)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .received_signal (line),
      .data            (data),
      .data_ready      (data_ready),
      .frame_error     (frame_error),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (data_ready) begin
            rdy_cnt++;
            last_rdy_cyc = cyc;
         end
         if (frame_error) ferr_cnt++;
         if (data_ready && frame_error) both_seen = 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n, input int per);
      for (int i = 0; i < n; i++) begin
         line = bits[i];
         tick(per);
      end
   endtask

   task automatic send_frame(input logic [DB-1:0] b, input logic stop, input int per);
      send_bits({6'd0, stop, b, 1'b0}, DB + 2, per);
   endtask

   // Frame-level model: a good stop bit delivers the byte, a bad one only flags an error.
   task automatic model_frame(input logic [DB-1:0] b, input logic stop);
      if (stop) begin
         exp_rdy++;
         exp_data = b;
      end else begin
         exp_ferr++;
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_rdy_count"}, rdy_cnt, exp_rdy);
      chk({tag, "_ferr_count"}, ferr_cnt, exp_ferr);
      chk({tag, "_data"}, data, exp_data);
   endtask

   initial begin
      logic [DB-1:0] b;
      logic          stop;
      int            gap;

      @(negedge clk);
      rst_n = 1'b0;
      tick(3);
      chk("reset_data", data, 0);
      chk("reset_data_ready", data_ready, 0);
      chk("reset_frame_error", frame_error, 0);
      chk("reset_busy", busy, 0);
      rst_n = 1'b1;
      tick(5);

      start_cyc = cyc;
      send_frame(8'hA5, 1'b1, CPB);
      model_frame(8'hA5, 1'b1);
      tick(4);
      chk("a5_latency", last_rdy_cyc - start_cyc, LAT);
      check_state("a5");

      send_frame(8'h00, 1'b1, CPB);
      model_frame(8'h00, 1'b1);
      check_state("b2b_00");
      send_frame(8'hFF, 1'b1, CPB);
      model_frame(8'hFF, 1'b1);
      tick(4);
      check_state("b2b_ff");

      line = 1'b0;
      tick(3);
      line = 1'b1;
      tick(2);
      chk("glitch_busy_start", busy, 1);
      tick(9);
      chk("glitch_busy_idle", busy, 0);
      check_state("glitch");

      b = 8'h3C;
      send_bits({6'd0, 1'b0, b, 1'b0}, DB + 2, CPB);
      tick(40 - CPB);
      chk("ferr_busy_break", busy, 1);
      model_frame(b, 1'b0);
      line = 1'b1;
      tick(6);
      chk("ferr_busy_idle", busy, 0);
      check_state("ferr");

      b = 8'h5A;
      send_bits({13'd0, b[1:0], 1'b0}, 3, CPB);
      line = b[2];
      tick(HALF);
      line = ~b[2];
      tick(1);
      line = b[2];
      tick(CPB - HALF - 1);
      send_bits({10'd0, 1'b1, b[7:3]}, 6, CPB);
      model_frame(b, 1'b1);
      tick(4);
      check_state("spike");

      b = 8'h6E;
      send_bits({11'd0, b[3:0], 1'b0}, 5, CPB);
      tick(HALF);
      rst_n = 1'b0;
      line  = 1'b1;
      #1;
      chk("midrst_data", data, 0);
      chk("midrst_data_ready", data_ready, 0);
      chk("midrst_frame_error", frame_error, 0);
      chk("midrst_busy", busy, 0);
      @(negedge clk);
      tick(2);
      rst_n = 1'b1;
      exp_data = '0;
      tick(30);
      check_state("midrst_idle");
      send_frame(8'h81, 1'b1, CPB);
      model_frame(8'h81, 1'b1);
      tick(4);
      check_state("after_rst_81");

      send_frame(8'hC3, 1'b1, CPB - 1);
      model_frame(8'hC3, 1'b1);
      tick(20);
      check_state("skew_fast");
      send_frame(8'h00, 1'b1, CPB);
      model_frame(8'h00, 1'b1);
      send_frame(8'hC3, 1'b1, CPB + 1);
      model_frame(8'hC3, 1'b1);
      tick(4);
      check_state("skew_slow");

      for (int i = 0; i < 8; i++) begin
         b    = DB'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         send_frame(b, stop, CPB);
         if (!stop) begin
            tick(CPB);
            line = 1'b1;
            gap  = int'($urandom_range(3, 6));
         end else begin
            gap  = int'($urandom_range(0, 4));
         end
         model_frame(b, stop);
         tick(gap);
         check_state("rand");
      end
      tick(4);
      chk("rdy_ferr_exclusive", both_seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
